// File: rtl/riscv_pkg.sv
// Shared encodings for the 5-stage core hazard logic: widths, forward selects, FSM, entry flags.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package riscv_pkg;

   localparam int REG_AW = 5;

   // Forwarding mux selects for an EX-stage operand
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } hz_state_t;

   // Control flags carried by every shadow pipeline entry; register fields are
   // sized by the instantiating block because they depend on its parameters.
   typedef struct packed {
      logic valid;
      logic regwrite;
      logic memread;
      logic memacc;
      logic branch;
   } entry_ctl_t;

endpackage

// File: rtl/fwd_cmp.sv
// Forwarding select for one EX source operand against the MEM and WB occupants.
// Latency: combinational.
// Backpressure: none; follows the scoreboard it is fed.
module fwd_cmp #(
   parameter int REG_AW = riscv_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] rs,
   input  logic              rs_used,
   input  logic              ex_valid,
   input  logic              mem_valid,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              wb_valid,
   input  logic              wb_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   output logic [1:0]        sel
);
   import riscv_pkg::*;

   logic mem_hit;
   logic wb_hit;

   // Youngest producer wins: MEM result is newer than the one in WB; x0 never forwards
   always_comb begin
      mem_hit = mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == rs);
      wb_hit  = wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == rs);
      sel     = FWD_RF;
      if (ex_valid && rs_used) begin
         if (mem_hit) begin
            sel = FWD_MEM;
         end else if (wb_hit) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Unified hazard unit: shadow EX/MEM/WB scoreboard driving stalls, flushes and forwarding.
// Latency: controls combinational from state+inputs; scoreboard updates one cycle later.
// Backpressure: dmem_ready low freezes IF..MEM; a wait of MEM_TIMEOUT cycles latches an error.
module hazard_ctrl #(
   parameter int REG_AW      = riscv_pkg::REG_AW,
   parameter int NUM_SRC     = 2,
   parameter int BR_STAGE    = 2,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]        id_rs_used,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_regwrite,
   input  logic                      id_memread,
   input  logic                      id_memwrite,
   input  logic                      id_branch,
   input  logic                      br_taken,
   input  logic                      dmem_ready,
   output logic                      pc_write,
   output logic                      if_id_write,
   output logic                      id_ex_bubble,
   output logic                      flush_if_id,
   output logic                      flush_id_ex,
   output logic                      flush_ex_mem,
   output logic                      mem_stall,
   output logic [NUM_SRC*2-1:0]      fwd_sel,
   output logic                      timeout_err
);
   import riscv_pkg::*;

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   typedef struct packed {
      entry_ctl_t                      ctl;
      logic [REG_AW-1:0]               rd;
      logic [NUM_SRC-1:0][REG_AW-1:0]  rs;
      logic [NUM_SRC-1:0]              rs_used;
   } entry_t;

   entry_t             id_ent, ex_q, mem_q, wb_q;
   hz_state_t          state_q, state_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic               mem_busy, stall_mem, br_live, br_flush, load_use;
   logic [NUM_SRC-1:0] lu_hit;
   logic               unused_wb;

   // Pack the ID-stage fields into the same layout as the shadow entries
   always_comb begin
      id_ent              = '0;
      id_ent.ctl.valid    = id_valid;
      id_ent.ctl.regwrite = id_regwrite;
      id_ent.ctl.memread  = id_memread;
      id_ent.ctl.memacc   = id_memread | id_memwrite;
      id_ent.ctl.branch   = id_branch;
      id_ent.rd           = id_rd;
      id_ent.rs           = id_rs;
      id_ent.rs_used      = id_rs_used;
   end

   // The resolving stage must really hold a branch for br_taken to count
   assign br_live = (BR_STAGE == 3) ? (mem_q.ctl.valid && mem_q.ctl.branch)
                                    : (ex_q.ctl.valid && ex_q.ctl.branch);

   // Hazard priority: memory wait/error, then taken branch, then load-use
   always_comb begin
      mem_busy  = mem_q.ctl.valid && mem_q.ctl.memacc && !dmem_ready;
      stall_mem = (state_q == ST_ERR) || mem_busy;
      br_flush  = !stall_mem && br_taken && br_live;
      lu_hit    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         lu_hit[i] = id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == ex_q.rd);
      end
      load_use  = !stall_mem && !br_flush && id_valid && ex_q.ctl.valid &&
                  ex_q.ctl.memread && (ex_q.rd != '0) && (|lu_hit);
   end

   assign pc_write     = !(stall_mem || load_use);
   assign if_id_write  = !(stall_mem || load_use);
   assign id_ex_bubble = load_use;
   assign flush_if_id  = br_flush;
   assign flush_id_ex  = br_flush;
   assign flush_ex_mem = br_flush && (BR_STAGE == 3);
   assign mem_stall    = stall_mem;
   assign timeout_err  = (state_q == ST_ERR);

   // Wait-state sequencing; ERR is left only through reset
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (mem_busy) begin
               state_nxt = ST_MEM_WAIT;
               cnt_nxt   = CNT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_busy) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
               if (cnt_q >= CNT_W'(MEM_TIMEOUT - 1)) begin
                  state_nxt = ST_ERR;
               end
            end
         end
         ST_ERR: begin
         end
         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // FSM state and wait counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // Shadow scoreboard: hold EX/MEM and bubble WB while memory stalls, otherwise shift
   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (stall_mem) begin
         wb_q <= '0;
      end else begin
         wb_q <= mem_q;
         if (br_flush && (BR_STAGE == 3)) begin
            mem_q <= '0;
         end else begin
            mem_q <= ex_q;
         end
         if (br_flush || load_use) begin
            ex_q <= '0;
         end else begin
            ex_q <= id_ent;
         end
      end
   end

   // WB only ever serves as a forwarding source, so its other fields go nowhere
   assign unused_wb = ^{wb_q.ctl.memread, wb_q.ctl.memacc, wb_q.ctl.branch, wb_q.rs, wb_q.rs_used};

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
      fwd_cmp #(
         .REG_AW(REG_AW)
      ) u_fwd (
         .rs           (ex_q.rs[g]),
         .rs_used      (ex_q.rs_used[g]),
         .ex_valid     (ex_q.ctl.valid),
         .mem_valid    (mem_q.ctl.valid),
         .mem_regwrite (mem_q.ctl.regwrite),
         .mem_rd       (mem_q.rd),
         .wb_valid     (wb_q.ctl.valid),
         .wb_regwrite  (wb_q.ctl.regwrite),
         .wb_rd        (wb_q.rd),
         .sel          (fwd_sel[g*2 +: 2])
      );
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table on a BR_STAGE=2 / MEM_TIMEOUT=4 instance,
// plus a hand-written sequence on a BR_STAGE=3 instance for the three-stage flush.
// Inputs change on the falling edge and outputs are compared 2 ns later.
module tb_hazard_ctrl;

   localparam int AW = 5;
   localparam int NS = 2;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rd;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs0;
      logic [1:0]    used;
      logic          rw;
      logic          mr;
      logic          mw;
      logic          br;
   } ins_t;

   // exp = {pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex,
   //        flush_ex_mem, mem_stall, timeout_err, fwd_sel[3:0]}
   typedef struct packed {
      logic        rst;
      logic        chk;
      ins_t        ins;
      logic        bt;
      logic        rdy;
      logic [11:0] exp;
   } vec_t;

   localparam ins_t NOP = '0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, id_valid, id_regwrite, id_memread, id_memwrite, id_branch;
   logic             br_taken, dmem_ready;
   logic [NS*AW-1:0] id_rs;
   logic [NS-1:0]    id_rs_used;
   logic [AW-1:0]    id_rd;

   logic       pcw2, ifw2, bub2, fi2, fd2, fm2, ms2, te2;
   logic       pcw3, ifw3, bub3, fi3, fd3, fm3, ms3, te3;
   logic [3:0] fwd2, fwd3;
   logic [11:0] obs2, obs3;

   assign obs2 = {pcw2, ifw2, bub2, fi2, fd2, fm2, ms2, te2, fwd2};
   assign obs3 = {pcw3, ifw3, bub3, fi3, fd3, fm3, ms3, te3, fwd3};

   hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .BR_STAGE(2), .MEM_TIMEOUT(4)) u_dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_memwrite(id_memwrite), .id_branch(id_branch), .br_taken(br_taken),
      .dmem_ready(dmem_ready), .pc_write(pcw2), .if_id_write(ifw2), .id_ex_bubble(bub2),
      .flush_if_id(fi2), .flush_id_ex(fd2), .flush_ex_mem(fm2), .mem_stall(ms2),
      .fwd_sel(fwd2), .timeout_err(te2)
   );

   hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .BR_STAGE(3), .MEM_TIMEOUT(16)) u_dut3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_memwrite(id_memwrite), .id_branch(id_branch), .br_taken(br_taken),
      .dmem_ready(dmem_ready), .pc_write(pcw3), .if_id_write(ifw3), .id_ex_bubble(bub3),
      .flush_if_id(fi3), .flush_id_ex(fd3), .flush_ex_mem(fm3), .mem_stall(ms3),
      .fwd_sel(fwd3), .timeout_err(te3)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t tab[$];

   function automatic ins_t alu(input logic [AW-1:0] rd, input logic [AW-1:0] a, input logic [AW-1:0] b);
      ins_t r = '0;
      r.valid = 1'b1; r.rd = rd; r.rs0 = a; r.rs1 = b; r.used = 2'b11; r.rw = 1'b1;
      return r;
   endfunction

   function automatic ins_t ld(input logic [AW-1:0] rd, input logic [AW-1:0] a);
      ins_t r = '0;
      r.valid = 1'b1; r.rd = rd; r.rs0 = a; r.used = 2'b01; r.rw = 1'b1; r.mr = 1'b1;
      return r;
   endfunction

   function automatic ins_t st(input logic [AW-1:0] a, input logic [AW-1:0] b);
      ins_t r = '0;
      r.valid = 1'b1; r.rs0 = a; r.rs1 = b; r.used = 2'b11; r.mw = 1'b1;
      return r;
   endfunction

   function automatic ins_t bra(input logic [AW-1:0] a, input logic [AW-1:0] b);
      ins_t r = '0;
      r.valid = 1'b1; r.rs0 = a; r.rs1 = b; r.used = 2'b11; r.br = 1'b1;
      return r;
   endfunction

   function automatic logic [11:0] e_run(input logic [3:0] f);
      return {8'b1100_0000, f};
   endfunction
   function automatic logic [11:0] e_lu(input logic [3:0] f);
      return {8'b0010_0000, f};
   endfunction
   function automatic logic [11:0] e_fl(input logic [3:0] f);
      return {8'b1101_1000, f};
   endfunction
   function automatic logic [11:0] e_fl3(input logic [3:0] f);
      return {8'b1101_1100, f};
   endfunction
   function automatic logic [11:0] e_ms(input logic te, input logic [3:0] f);
      return {7'b0000_001, te, f};
   endfunction

   task automatic add(input logic r, input logic c, input ins_t i, input logic bt,
                      input logic rdy, input logic [11:0] e);
      vec_t v;
      v.rst = r; v.chk = c; v.ins = i; v.bt = bt; v.rdy = rdy; v.exp = e;
      tab.push_back(v);
   endtask

   task automatic drive(input logic r, input ins_t i, input logic bt, input logic rdy);
      @(negedge clk);
      rst         = r;
      id_valid    = i.valid;
      id_rs       = {i.rs1, i.rs0};
      id_rs_used  = i.used;
      id_rd       = i.rd;
      id_regwrite = i.rw;
      id_memread  = i.mr;
      id_memwrite = i.mw;
      id_branch   = i.br;
      br_taken    = bt;
      dmem_ready  = rdy;
      #2;
   endtask

   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", nm, act, exp);
      end
   endtask

   initial begin
      rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
      id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0; id_branch = 1'b0;
      br_taken = 1'b0; dmem_ready = 1'b1;

      // reset, then load-use: ld x5,0(x1); add x6,x5,x2 (add reaches EX with WB forward on src0)
      add(0, 0, NOP,           0, 1, e_run(4'b0000));
      add(0, 1, NOP,           0, 1, e_run(4'b0000));
      add(1, 1, ld(5, 1),      0, 1, e_run(4'b0000));
      add(1, 1, alu(6, 5, 2),  0, 1, e_lu(4'b0000));
      add(1, 1, alu(6, 5, 2),  0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b0001));
      // add x3,x1,x2; sub x4,x3,x3 -> both sources from MEM
      add(1, 1, alu(3, 1, 2),  0, 1, e_run(4'b0000));
      add(1, 1, alu(4, 3, 3),  0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b1010));
      add(1, 1, NOP,           0, 1, e_run(4'b0000));
      // x7 in both MEM and WB -> MEM wins
      add(1, 1, alu(7, 1, 2),  0, 1, e_run(4'b0000));
      add(1, 1, alu(7, 1, 2),  0, 1, e_run(4'b0000));
      add(1, 1, alu(8, 7, 7),  0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b1010));
      // producer writes x0 -> never forwarded
      add(1, 1, alu(0, 1, 2),  0, 1, e_run(4'b0000));
      add(1, 1, alu(4, 0, 0),  0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b0000));
      // taken branch in EX, then br_taken with no branch in EX is ignored
      add(1, 1, bra(1, 2),     0, 1, e_run(4'b0000));
      add(1, 1, alu(11, 1, 2), 1, 1, e_fl(4'b0000));
      add(1, 1, NOP,           1, 1, e_run(4'b0000));
      add(1, 1, alu(12, 1, 2), 1, 1, e_run(4'b0000));
      add(1, 1, NOP,           1, 1, e_run(4'b0000));
      // load in MEM waits 3 cycles, then the load lands in WB and feeds the consumer
      add(1, 1, ld(13, 1),     0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b0000));
      add(1, 1, alu(14, 13, 3), 0, 0, e_ms(1'b0, 4'b0000));
      add(1, 1, alu(14, 13, 3), 0, 0, e_ms(1'b0, 4'b0000));
      add(1, 1, alu(14, 13, 3), 0, 0, e_ms(1'b0, 4'b0000));
      add(1, 1, alu(14, 13, 3), 0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b0001));
      // store never acknowledged -> ERR after 4 wait cycles, sticky until reset
      add(1, 1, st(1, 2),      0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 0, e_ms(1'b0, 4'b0000));
      add(1, 1, NOP,           0, 0, e_ms(1'b0, 4'b0000));
      add(1, 1, NOP,           0, 0, e_ms(1'b0, 4'b0000));
      add(1, 1, NOP,           0, 0, e_ms(1'b0, 4'b0000));
      add(1, 1, NOP,           0, 1, e_ms(1'b1, 4'b0000));
      add(1, 1, NOP,           1, 1, e_ms(1'b1, 4'b0000));
      add(0, 1, NOP,           0, 1, e_ms(1'b1, 4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b0000));
      // reset during MEM_WAIT: no stall and no load-use against the old loads afterwards
      add(1, 1, ld(15, 1),     0, 1, e_run(4'b0000));
      add(1, 1, ld(16, 1),     0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 0, e_ms(1'b0, 4'b0000));
      add(0, 1, NOP,           0, 0, e_ms(1'b0, 4'b0000));
      add(1, 1, alu(17, 16, 15), 0, 0, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b0000));
      // load-use on the second source, forwarded from WB on src1
      add(1, 1, ld(18, 2),     0, 1, e_run(4'b0000));
      add(1, 1, alu(19, 1, 18), 0, 1, e_lu(4'b0000));
      add(1, 1, alu(19, 1, 18), 0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b0100));
      // load to x0 causes no stall; ALU producer never causes a stall
      add(1, 1, ld(0, 1),      0, 1, e_run(4'b0000));
      add(1, 1, alu(1, 0, 0),  0, 1, e_run(4'b0000));
      add(1, 1, alu(21, 1, 1), 0, 1, e_run(4'b0000));
      add(1, 1, NOP,           0, 1, e_run(4'b1010));

      for (int k = 0; k < tab.size(); k++) begin
         drive(tab[k].rst, tab[k].ins, tab[k].bt, tab[k].rdy);
         if (tab[k].chk) begin
            check($sformatf("br2_vec%0d", k), obs2, tab[k].exp);
         end
      end

      // BR_STAGE=3: branch in MEM flushes three stages and drops a coinciding load-use
      drive(0, NOP, 0, 1);
      drive(1, bra(1, 2), 1, 1);
      check("br3_reset_state", obs3, e_run(4'b0000));
      drive(1, ld(5, 1), 1, 1);
      check("br3_branch_in_ex_ignored", obs3, e_run(4'b0000));
      drive(1, alu(6, 5, 2), 1, 1);
      check("br3_flush_over_load_use", obs3, e_fl3(4'b0000));
      drive(1, alu(6, 5, 2), 1, 0);
      check("br3_ex_mem_squashed", obs3, e_run(4'b0000));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
